// File: rtl/scan_tap_if.sv
// Scan-chain pin bundle between the scanchain controller and scan_tap.
// The controller side drives tck/tms/tdi and the parallel capture data;
// the TAP side returns tdo, the return clock and the parallel update port.
interface scan_tap_if;
    logic       tck;
    logic       tms;
    logic       tdi;
    logic [7:0] dr_in;
    logic       tdo;
    logic       rtck;
    logic [7:0] dr_out;
    logic       update_stb;

    modport master (
        output tck,
        output tms,
        output tdi,
        output dr_in,
        input  tdo,
        input  rtck,
        input  dr_out,
        input  update_stb
    );

    modport slave (
        input  tck,
        input  tms,
        input  tdi,
        input  dr_in,
        output tdo,
        output rtck,
        output dr_out,
        output update_stb
    );
endinterface

// File: rtl/scan_tap.sv
// IEEE 1149.1 style TAP running entirely in the clk domain.
// tck/tms/tdi are oversampled through matched synchronisers; edges of the
// synchronised tck drive the 16-state TAP FSM, a 2-bit IR and three data
// registers (8-bit DATA, 8-bit IDCODE, 1-bit BYPASS).
module scan_tap #(
    parameter logic [7:0]  IDCODE      = 8'hA5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     reset,
    scan_tap_if.slave bus
);

    localparam logic [1:0] IrData   = 2'b00;
    localparam logic [1:0] IrIdcode = 2'b01;

    typedef enum logic [3:0] {
        StTlr,
        StRti,
        StSelDr,
        StCapDr,
        StShDr,
        StEx1Dr,
        StPaDr,
        StEx2Dr,
        StUpdDr,
        StSelIr,
        StCapIr,
        StShIr,
        StEx1Ir,
        StPaIr,
        StEx2Ir,
        StUpdIr
    } tap_state_e;

    // Synchroniser chains; bit 0 is the first stage.
    logic [SYNC_STAGES-1:0] tck_sync_q;
    logic [SYNC_STAGES-1:0] tms_sync_q;
    logic [SYNC_STAGES-1:0] tdi_sync_q;

    logic tck_s;
    logic tms_s;
    logic tdi_s;
    logic rtck_q;
    logic rise;
    logic fall;

    tap_state_e state_q;
    tap_state_e state_d;
    tap_state_e tap_next;

    logic [1:0] ir_q;
    logic [1:0] ir_d;
    logic [1:0] ir_shift_q;
    logic [1:0] ir_shift_d;
    logic [7:0] dr_shift_q;
    logic [7:0] dr_shift_d;
    logic       bypass_q;
    logic       bypass_d;
    logic [7:0] dr_out_q;
    logic [7:0] dr_out_d;
    logic       update_stb_q;
    logic       update_stb_d;
    logic       tdo_q;
    logic       tdo_d;
    logic       bypass_sel;

    // Identical chains keep tck, tms and tdi cycle-aligned at the far end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            rtck_q     <= 1'b0;
        end else begin
            tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], bus.tck};
            tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], bus.tms};
            tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], bus.tdi};
            rtck_q     <= tck_s;
        end
    end

    assign tck_s = tck_sync_q[SYNC_STAGES-1];
    assign tms_s = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s = tdi_sync_q[SYNC_STAGES-1];

    // rtck is the previous synchronised tck, so comparing the two gives edges.
    assign rise = tck_s & ~rtck_q;
    assign fall = ~tck_s & rtck_q;

    // IR values other than DATA and IDCODE select the 1-bit bypass register.
    assign bypass_sel = (ir_q != IrData) && (ir_q != IrIdcode);

    // Standard TAP transition table, evaluated against the synchronised tms.
    always_comb begin
        tap_next = state_q;
        unique case (state_q)
            StTlr:   tap_next = tms_s ? StTlr   : StRti;
            StRti:   tap_next = tms_s ? StSelDr : StRti;
            StSelDr: tap_next = tms_s ? StSelIr : StCapDr;
            StCapDr: tap_next = tms_s ? StEx1Dr : StShDr;
            StShDr:  tap_next = tms_s ? StEx1Dr : StShDr;
            StEx1Dr: tap_next = tms_s ? StUpdDr : StPaDr;
            StPaDr:  tap_next = tms_s ? StEx2Dr : StPaDr;
            StEx2Dr: tap_next = tms_s ? StUpdDr : StShDr;
            StUpdDr: tap_next = tms_s ? StSelDr : StRti;
            StSelIr: tap_next = tms_s ? StTlr   : StCapIr;
            StCapIr: tap_next = tms_s ? StEx1Ir : StShIr;
            StShIr:  tap_next = tms_s ? StEx1Ir : StShIr;
            StEx1Ir: tap_next = tms_s ? StUpdIr : StPaIr;
            StPaIr:  tap_next = tms_s ? StEx2Ir : StPaIr;
            StEx2Ir: tap_next = tms_s ? StUpdIr : StShIr;
            StUpdIr: tap_next = tms_s ? StSelIr : StRti;
            default: tap_next = StTlr;
        endcase
    end

    // The FSM only moves on a rising-edge event.
    always_comb begin
        state_d = state_q;
        if (rise) begin
            state_d = tap_next;
        end
    end

    // Register actions: shifting is keyed by the current state, capture and
    // update by the state being entered on this rising edge.
    always_comb begin
        ir_d         = ir_q;
        ir_shift_d   = ir_shift_q;
        dr_shift_d   = dr_shift_q;
        bypass_d     = bypass_q;
        dr_out_d     = dr_out_q;
        update_stb_d = 1'b0;
        tdo_d        = tdo_q;

        if (state_q == StTlr) begin
            ir_d = IrIdcode;
        end

        if (rise) begin
            if (state_q == StShIr) begin
                ir_shift_d = {tdi_s, ir_shift_q[1]};
            end
            if (state_q == StShDr) begin
                if (bypass_sel) begin
                    bypass_d = tdi_s;
                end else begin
                    dr_shift_d = {tdi_s, dr_shift_q[7:1]};
                end
            end

            case (tap_next)
                StTlr: begin
                    ir_d = IrIdcode;
                end
                StCapIr: begin
                    ir_shift_d = 2'b01;
                end
                StUpdIr: begin
                    ir_d = ir_shift_q;
                end
                StCapDr: begin
                    if (ir_q == IrData) begin
                        dr_shift_d = bus.dr_in;
                    end else if (ir_q == IrIdcode) begin
                        dr_shift_d = IDCODE;
                    end else begin
                        bypass_d = 1'b0;
                    end
                end
                StUpdDr: begin
                    if (ir_q == IrData) begin
                        dr_out_d     = dr_shift_q;
                        update_stb_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // tdo changes only on falling edges and holds otherwise.
        if (fall) begin
            if (state_q == StShDr) begin
                tdo_d = bypass_sel ? bypass_q : dr_shift_q[0];
            end else if (state_q == StShIr) begin
                tdo_d = ir_shift_q[0];
            end else begin
                tdo_d = 1'b0;
            end
        end
    end

    // FSM and register state; reset aborts any scan in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StTlr;
            ir_q         <= IrIdcode;
            ir_shift_q   <= '0;
            dr_shift_q   <= '0;
            bypass_q     <= 1'b0;
            dr_out_q     <= '0;
            update_stb_q <= 1'b0;
            tdo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            ir_shift_q   <= ir_shift_d;
            dr_shift_q   <= dr_shift_d;
            bypass_q     <= bypass_d;
            dr_out_q     <= dr_out_d;
            update_stb_q <= update_stb_d;
            tdo_q        <= tdo_d;
        end
    end

    assign bus.tdo        = tdo_q;
    assign bus.rtck       = rtck_q;
    assign bus.dr_out     = dr_out_q;
    assign bus.update_stb = update_stb_q;

endmodule

// File: tb/tb_scan_tap.sv
// Directed bench for scan_tap: a table of tck pulses with expected tdo and
// parallel-update results, plus hand-written reset, glitch and pause cases.
module tb_scan_tap;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic       chk_tdo;
        logic       exp_tdo;
        logic       chk_dr;
        logic [7:0] exp_dr;
        int         exp_stb;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   stb_count;
    vec_t vecs[$];

    scan_tap_if bus ();

    scan_tap #(
        .IDCODE      (8'hA5),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Total clk cycles the strobe was high; a single pulse adds exactly one.
    always @(posedge clk) begin
        if (bus.update_stb === 1'b1) stb_count <= stb_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One long tck period: 6 clk high, 6 clk low, ending on a clk negedge.
    task automatic tck_pulse(input logic tms_v, input logic tdi_v);
        @(negedge clk);
        bus.tms = tms_v;
        bus.tdi = tdi_v;
        bus.tck = 1'b1;
        repeat (6) @(negedge clk);
        bus.tck = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic add_vec(input logic tms_v, input logic tdi_v, input logic chk_t,
                           input logic exp_t, input logic chk_d, input logic [7:0] exp_d,
                           input int exp_s);
        vec_t v;
        v.tms     = tms_v;
        v.tdi     = tdi_v;
        v.chk_tdo = chk_t;
        v.exp_tdo = exp_t;
        v.chk_dr  = chk_d;
        v.exp_dr  = exp_d;
        v.exp_stb = exp_s;
        vecs.push_back(v);
    endtask

    task automatic add_nav(input logic tms_v);
        add_vec(tms_v, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    endtask

    task automatic add_shift(input logic tms_v, input logic tdi_v, input logic exp_t);
        add_vec(tms_v, tdi_v, 1'b1, exp_t, 1'b0, 8'h00, 0);
    endtask

    initial begin
        logic [7:0] v_idc;
        logic [7:0] v_3c;
        logic [7:0] v_c3;
        logic [7:0] v_96;
        logic [7:0] v_5a;
        int         n;

        v_idc     = 8'hA5;
        v_3c      = 8'h3C;
        v_c3      = 8'hC3;
        v_96      = 8'h96;
        v_5a      = 8'h5A;
        checks    = 0;
        errors    = 0;
        stb_count = 0;

        // IDCODE scan from a fresh TLR.
        for (int i = 0; i < 5; i++) add_nav(1'b1);
        add_nav(1'b0); add_nav(1'b1); add_nav(1'b0); add_nav(1'b0);
        for (int i = 0; i < 8; i++) add_shift(i == 7, 1'b0, v_idc[i]);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0);
        add_nav(1'b0);
        // IR <= DATA, then capture 3C while shifting in C3.
        add_nav(1'b1); add_nav(1'b1); add_nav(1'b0); add_nav(1'b0);
        add_shift(1'b0, 1'b0, 1'b1);
        add_shift(1'b1, 1'b0, 1'b0);
        add_nav(1'b1); add_nav(1'b0);
        add_nav(1'b1); add_nav(1'b0); add_nav(1'b0);
        for (int i = 0; i < 8; i++) add_shift(i == 7, v_c3[i], v_3c[i]);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1);
        add_nav(1'b0);
        // IR <= BYPASS (11): one-bit delay, no parallel update.
        add_nav(1'b1); add_nav(1'b1); add_nav(1'b0); add_nav(1'b0);
        add_shift(1'b0, 1'b1, 1'b1);
        add_shift(1'b1, 1'b1, 1'b0);
        add_nav(1'b1); add_nav(1'b0);
        add_nav(1'b1); add_nav(1'b0); add_nav(1'b0);
        for (int i = 0; i < 8; i++) add_shift(i == 7, 1'b1, i != 0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1);
        add_nav(1'b0);

        bus.tck   = 1'b0;
        bus.tms   = 1'b0;
        bus.tdi   = 1'b0;
        bus.dr_in = 8'h3C;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tdo", 32'(bus.tdo), 32'd0);
        check("reset rtck", 32'(bus.rtck), 32'd0);
        check("reset dr_out", 32'(bus.dr_out), 32'h00);
        check("reset update_stb", 32'(bus.update_stb), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // rtck latency: count clk edges from tck rise until rtck follows.
        bus.tms = 1'b1;
        bus.tck = 1'b1;
        n = 0;
        while (bus.rtck !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rtck latency", 32'(n), 32'd3);
        bus.tck = 1'b0;
        repeat (6) @(negedge clk);

        // Sub-clk glitch between clk edges must not advance TLR -> RTI.
        bus.tms = 1'b0;
        @(negedge clk);
        #1 bus.tck = 1'b1;
        #2 bus.tck = 1'b0;
        repeat (10) @(negedge clk);
        tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0); tck_pulse(1'b0, 1'b0);
        check("glitch ignored tdo", 32'(bus.tdo), 32'd0);
        tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0); tck_pulse(1'b0, 1'b0);
        check("glitch sh_dr tdo", 32'(bus.tdo), 32'd1);

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].chk_tdo) begin
                check($sformatf("vec%0d tdo", k), 32'(bus.tdo), 32'(vecs[k].exp_tdo));
            end
            tck_pulse(vecs[k].tms, vecs[k].tdi);
            if (vecs[k].chk_dr) begin
                check($sformatf("vec%0d dr_out", k), 32'(bus.dr_out), 32'(vecs[k].exp_dr));
                check($sformatf("vec%0d stb count", k), 32'(stb_count), 32'(vecs[k].exp_stb));
            end
        end

        // Pause-DR for 20 tck cycles in the middle of a DATA scan.
        tck_pulse(1'b1, 1'b0); tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0); tck_pulse(1'b0, 1'b0); tck_pulse(1'b1, 1'b0);
        tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0);
        bus.dr_in = 8'h96;
        tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0); tck_pulse(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pause pre tdo%0d", i), 32'(bus.tdo), 32'(v_96[i]));
            tck_pulse(i == 3, v_5a[i]);
        end
        tck_pulse(1'b0, 1'b0);
        repeat (20) tck_pulse(1'b0, 1'b1);
        check("pause tdo", 32'(bus.tdo), 32'd0);
        tck_pulse(1'b1, 1'b0);
        tck_pulse(1'b0, 1'b0);
        for (int i = 4; i < 8; i++) begin
            check($sformatf("pause post tdo%0d", i), 32'(bus.tdo), 32'(v_96[i]));
            tck_pulse(i == 7, v_5a[i]);
        end
        tck_pulse(1'b1, 1'b0);
        check("pause dr_out", 32'(bus.dr_out), 32'h5A);
        check("pause stb count", 32'(stb_count), 32'd2);
        tck_pulse(1'b0, 1'b0);

        // Reset in the middle of a DATA shift, with tck held high.
        tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0); tck_pulse(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tck_pulse(1'b0, 1'b1);
        check("pre-reset tdo", 32'(bus.tdo), 32'(v_96[4]));
        @(negedge clk);
        bus.tms = 1'b1;
        bus.tck = 1'b1;
        repeat (4) @(negedge clk);
        check("pre-reset rtck", 32'(bus.rtck), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid reset tdo", 32'(bus.tdo), 32'd0);
        check("mid reset rtck", 32'(bus.rtck), 32'd0);
        check("mid reset dr_out", 32'(bus.dr_out), 32'h00);
        check("mid reset update_stb", 32'(bus.update_stb), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        bus.tck = 1'b0;
        repeat (6) @(negedge clk);
        check("post reset dr_out", 32'(bus.dr_out), 32'h00);
        check("post reset stb count", 32'(stb_count), 32'd2);
        // From TLR with IR forced to IDCODE, Shift-DR shows A5 bit 0.
        tck_pulse(1'b0, 1'b0); tck_pulse(1'b1, 1'b0);
        tck_pulse(1'b0, 1'b0); tck_pulse(1'b0, 1'b0);
        check("post reset idcode tdo", 32'(bus.tdo), 32'(v_idc[0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
